otter_hamm_decoder: RTL and testbench

//  Read-side Hamming(38,32) SEC checker/corrector for the OTTER parity memory.

---
 rtl/otter_hamm_decoder.sv | 151 +++++++++++++++
 tb/tb_otter_hamm_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_hamm_decoder.sv
// otter_hamm_decoder: Hamming(38,32) SEC read-side checker/corrector behind a 2-stage valid/ready pipeline.
// Define OTTER_HAMM_CORRECT_EN to correct data-bit errors; left undefined the block is detect-only.
module otter_hamm_decoder #(
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  MEM_CLK,
  input  logic                  MEM_RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [31:0]           IN_DATA,
  input  logic [5:0]            IN_PAR,
  input  logic [ADDR_WIDTH-1:0] IN_ADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [31:0]           OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic [5:0]            OUT_SYND,
  output logic                  OUT_CORR,
  output logic                  OUT_UNCORR,
  input  logic                  CNT_CLR,
  output logic [CNT_WIDTH-1:0]  CORR_CNT,
  output logic [CNT_WIDTH-1:0]  UNCORR_CNT,
  output logic                  ERR_LOG_VALID,
  output logic [ADDR_WIDTH-1:0] ERR_LOG_ADDR
);

  // Codeword position of data bit idx: the idx-th non-power-of-two position starting at 3.
  function automatic logic [5:0] dataPos(input int idx);
    int         cnt;
    logic [5:0] pos;
    cnt = 0;
    pos = '0;
    for (int p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = 6'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [5:0] calcCheck(input logic [31:0] d);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) c = c ^ dataPos(i);
    end
    return c;
  endfunction

  logic                  w_stall;
  logic                  w_xfer;
  logic [5:0]            w_synd;
  logic                  w_isCorr;
  logic                  w_isUncorr;
  logic [31:0]           w_corrData;

  logic                  r_s1Valid;
  logic [31:0]           r_s1Data;
  logic [ADDR_WIDTH-1:0] r_s1Addr;
  logic [5:0]            r_s1Synd;

  logic [CNT_WIDTH-1:0]  r_corrCnt;
  logic [CNT_WIDTH-1:0]  r_uncorrCnt;
  logic                  r_logValid;
  logic [ADDR_WIDTH-1:0] r_logAddr;

  assign w_stall  = OUT_VALID && !OUT_READY;
  assign w_xfer   = OUT_VALID && OUT_READY;
  assign IN_READY = !w_stall;
  assign w_synd   = calcCheck(IN_DATA) ^ IN_PAR;

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Addr  <= '0;
      r_s1Synd  <= '0;
    end else if (!w_stall) begin
      r_s1Valid <= IN_VALID;
      r_s1Data  <= IN_DATA;
      r_s1Addr  <= IN_ADDR;
      r_s1Synd  <= w_synd;
    end
  end

  // Syndromes 1..38 name a codeword position; anything above 38 points outside the code.
  assign w_isUncorr = r_s1Synd > 6'd38;
  assign w_isCorr   = (r_s1Synd != 6'd0) && !w_isUncorr;

`ifdef OTTER_HAMM_CORRECT_EN
  logic [31:0] w_flipMask;

  always_comb begin
    w_flipMask = '0;
    for (int i = 0; i < 32; i++) begin
      if (dataPos(i) == r_s1Synd) w_flipMask[i] = 1'b1;
    end
  end

  assign w_corrData = r_s1Data ^ w_flipMask;
`else
  assign w_corrData = r_s1Data;
`endif

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
      OUT_ADDR   <= '0;
      OUT_SYND   <= '0;
      OUT_CORR   <= 1'b0;
      OUT_UNCORR <= 1'b0;
    end else if (!w_stall) begin
      OUT_VALID  <= r_s1Valid;
      OUT_DATA   <= w_corrData;
      OUT_ADDR   <= r_s1Addr;
      OUT_SYND   <= r_s1Synd;
      OUT_CORR   <= w_isCorr;
      OUT_UNCORR <= w_isUncorr;
    end
  end

  // Statistics only count delivered words; a clear in the same cycle takes priority.
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST || CNT_CLR) begin
      r_corrCnt   <= '0;
      r_uncorrCnt <= '0;
      r_logValid  <= 1'b0;
      r_logAddr   <= '0;
    end else if (w_xfer) begin
      if (OUT_CORR && (r_corrCnt != {CNT_WIDTH{1'b1}})) begin
        r_corrCnt <= r_corrCnt + CNT_WIDTH'(1);
      end
      if (OUT_UNCORR && (r_uncorrCnt != {CNT_WIDTH{1'b1}})) begin
        r_uncorrCnt <= r_uncorrCnt + CNT_WIDTH'(1);
      end
      if (OUT_UNCORR && !r_logValid) begin
        r_logValid <= 1'b1;
        r_logAddr  <= OUT_ADDR;
      end
    end
  end

  assign CORR_CNT      = r_corrCnt;
  assign UNCORR_CNT    = r_uncorrCnt;
  assign ERR_LOG_VALID = r_logValid;
  assign ERR_LOG_ADDR  = r_logAddr;

endmodule

// File: tb/tb_otter_hamm_decoder.sv
// tb_otter_hamm_decoder: directed vector table, handshake sequences and randomized traffic
// against a codeword-level Hamming reference model (follows OTTER_HAMM_CORRECT_EN).
module tb_otter_hamm_decoder;
  localparam int AW = 14;
  localparam int CW = 4;
`ifdef OTTER_HAMM_CORRECT_EN
  localparam bit CorrectEn = 1'b1;
`else
  localparam bit CorrectEn = 1'b0;
`endif

  logic          MEM_CLK;
  logic          MEM_RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [31:0]   IN_DATA;
  logic [5:0]    IN_PAR;
  logic [AW-1:0] IN_ADDR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [31:0]   OUT_DATA;
  logic [AW-1:0] OUT_ADDR;
  logic [5:0]    OUT_SYND;
  logic          OUT_CORR;
  logic          OUT_UNCORR;
  logic          CNT_CLR;
  logic [CW-1:0] CORR_CNT;
  logic [CW-1:0] UNCORR_CNT;
  logic          ERR_LOG_VALID;
  logic [AW-1:0] ERR_LOG_ADDR;

  otter_hamm_decoder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST(MEM_RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_PAR(IN_PAR), .IN_ADDR(IN_ADDR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR),
    .OUT_SYND(OUT_SYND), .OUT_CORR(OUT_CORR), .OUT_UNCORR(OUT_UNCORR),
    .CNT_CLR(CNT_CLR), .CORR_CNT(CORR_CNT), .UNCORR_CNT(UNCORR_CNT),
    .ERR_LOG_VALID(ERR_LOG_VALID), .ERR_LOG_ADDR(ERR_LOG_ADDR)
  );

  initial MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    logic [5:0]    synd;
    logic          corr;
    logic          uncorr;
  } expT;

  typedef struct {
    logic [31:0]   data;
    logic [5:0]    par;
    logic [AW-1:0] addr;
    logic [31:0]   expData;
    logic [5:0]    expSynd;
    logic          expCorr;
    logic          expUncorr;
  } vecT;

  expT           expQ[$];
  int            nCompared = 0;
  int            nMismatched = 0;
  int            mCorr = 0;
  int            mUncorr = 0;
  logic          mLogValid = 1'b0;
  logic [AW-1:0] mLogAddr = '0;
  bit            lastAccepted;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: build the 38-bit codeword, syndrome = XOR of the positions of all set bits.
  function automatic expT refModel(input logic [31:0] d, input logic [5:0] par, input logic [AW-1:0] a);
    logic [38:0] cw;
    logic [5:0]  s;
    int          k;
    expT         r;
    cw = '0;
    for (int b = 0; b < 6; b++) cw[1 << b] = par[b];
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    s = '0;
    for (int p = 1; p <= 38; p++) begin
      if (cw[p]) s = s ^ 6'(p);
    end
    r.synd   = s;
    r.corr   = (s != 6'd0) && (s <= 6'd38);
    r.uncorr = (s > 6'd38);
    if (CorrectEn && r.corr) cw[s] = ~cw[s];
    r.data = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.data[k] = cw[p];
        k++;
      end
    end
    r.addr = a;
    return r;
  endfunction

  function automatic logic [5:0] encode(input logic [31:0] d);
    expT r;
    r = refModel(d, 6'd0, '0);
    return r.synd;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [5:0] p, input logic [AW-1:0] a);
    IN_VALID = v;
    IN_DATA  = d;
    IN_PAR   = p;
    IN_ADDR  = a;
  endtask

  // One clock: check outputs/stats at the negedge, advance the model, return at posedge+1.
  task automatic tick();
    expT h;
    bit  xfer;
    bit  acc;
    @(negedge MEM_CLK);
    checkOutput("in_ready", 64'(IN_READY), 64'(!(OUT_VALID && !OUT_READY)));
    checkOutput("corr_cnt", 64'(CORR_CNT), 64'(mCorr));
    checkOutput("uncorr_cnt", 64'(UNCORR_CNT), 64'(mUncorr));
    checkOutput("log_valid", 64'(ERR_LOG_VALID), 64'(mLogValid));
    checkOutput("log_addr", 64'(ERR_LOG_ADDR), 64'(mLogAddr));
    if (OUT_VALID === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_out: OUT_VALID=1 with no word outstanding, required 0");
      end else begin
        h = expQ[0];
        checkOutput("out_data", 64'(OUT_DATA), 64'(h.data));
        checkOutput("out_addr", 64'(OUT_ADDR), 64'(h.addr));
        checkOutput("out_synd", 64'(OUT_SYND), 64'(h.synd));
        checkOutput("out_corr", 64'(OUT_CORR), 64'(h.corr));
        checkOutput("out_uncorr", 64'(OUT_UNCORR), 64'(h.uncorr));
      end
    end
    xfer = (OUT_VALID === 1'b1) && (OUT_READY === 1'b1);
    acc  = (IN_VALID === 1'b1) && !((OUT_VALID === 1'b1) && (OUT_READY !== 1'b1));
    lastAccepted = 1'b0;
    if (MEM_RST) begin
      expQ.delete();
      mCorr = 0;
      mUncorr = 0;
      mLogValid = 1'b0;
      mLogAddr = '0;
    end else begin
      if (xfer && expQ.size() > 0) begin
        h = expQ.pop_front();
        if (h.corr && mCorr < (1 << CW) - 1) mCorr++;
        if (h.uncorr && mUncorr < (1 << CW) - 1) mUncorr++;
        if (h.uncorr && !mLogValid) begin
          mLogValid = 1'b1;
          mLogAddr = h.addr;
        end
      end
      if (CNT_CLR) begin
        mCorr = 0;
        mUncorr = 0;
        mLogValid = 1'b0;
        mLogAddr = '0;
      end
      if (acc) begin
        expQ.push_back(refModel(IN_DATA, IN_PAR, IN_ADDR));
        lastAccepted = 1'b1;
      end
    end
    @(posedge MEM_CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    applyStimulus(1'b0, '0, '0, '0);
    OUT_READY = 1'b1;
    t = 0;
    while (expQ.size() > 0 && t < 30) begin
      tick();
      t++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  vecT vecs[10];

  initial begin
    logic [31:0] d;
    logic [5:0]  p;
    int          k;
    int          t;
    int          mode;

    vecs[0] = '{32'h00000001, 6'b000011, 14'h0010, 32'h00000001, 6'd0, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 6'b000011, 14'h0011, (CorrectEn ? 32'h00000001 : 32'h0), 6'd3, 1'b1, 1'b0};
    vecs[2] = '{32'h00000000, 6'b000100, 14'h0012, 32'h00000000, 6'd4, 1'b1, 1'b0};
    vecs[3] = '{32'h00000000, 6'b111111, 14'h0123, 32'h00000000, 6'd63, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 6'b100001, 14'h0013, (CorrectEn ? 32'h04000000 : 32'h0), 6'd33, 1'b1, 1'b0};
    vecs[5] = '{32'h00000000, 6'b100000, 14'h0014, 32'h00000000, 6'd32, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 6'b100110, 14'h0015, (CorrectEn ? 32'h80000000 : 32'h0), 6'd38, 1'b1, 1'b0};
    vecs[7] = '{32'h00000000, 6'b100111, 14'h0200, 32'h00000000, 6'd39, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFFFFFF, 6'b011000, 14'h0016, 32'hFFFFFFFF, 6'd0, 1'b0, 1'b0};
    vecs[9] = '{32'hFFFFFFFF, 6'b000000, 14'h0017, (CorrectEn ? 32'hFFFBFFFF : 32'hFFFFFFFF), 6'd24, 1'b1, 1'b0};

    applyStimulus(1'b0, '0, '0, '0);
    OUT_READY = 1'b1;
    CNT_CLR   = 1'b0;
    MEM_RST   = 1'b1;
    repeat (2) @(posedge MEM_CLK);
    #1;
    MEM_RST = 1'b0;
    checkOutput("rst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("rst_in_ready", 64'(IN_READY), 64'd1);
    checkOutput("rst_corr_cnt", 64'(CORR_CNT), 64'd0);
    checkOutput("rst_uncorr_cnt", 64'(UNCORR_CNT), 64'd0);
    checkOutput("rst_log_valid", 64'(ERR_LOG_VALID), 64'd0);
    checkOutput("rst_log_addr", 64'(ERR_LOG_ADDR), 64'd0);

    // Directed vectors, each checked for exact 2-cycle latency.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].par, vecs[i].addr);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput($sformatf("vec%0d_lat1", i), 64'(OUT_VALID), 64'd0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 64'(OUT_VALID), 64'd1);
      checkOutput($sformatf("vec%0d_data", i), 64'(OUT_DATA), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_synd", i), 64'(OUT_SYND), 64'(vecs[i].expSynd));
      checkOutput($sformatf("vec%0d_corr", i), 64'(OUT_CORR), 64'(vecs[i].expCorr));
      checkOutput($sformatf("vec%0d_uncorr", i), 64'(OUT_UNCORR), 64'(vecs[i].expUncorr));
      tick();
    end
    tick();
    checkOutput("tbl_corr_cnt", 64'(CORR_CNT), 64'd6);
    checkOutput("tbl_uncorr_cnt", 64'(UNCORR_CNT), 64'd2);
    checkOutput("tbl_log_valid", 64'(ERR_LOG_VALID), 64'd1);
    checkOutput("tbl_log_addr", 64'(ERR_LOG_ADDR), 64'h0123);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    checkOutput("clr_corr_cnt", 64'(CORR_CNT), 64'd0);
    checkOutput("clr_log_valid", 64'(ERR_LOG_VALID), 64'd0);
    checkOutput("clr_log_addr", 64'(ERR_LOG_ADDR), 64'd0);

    // Clear coinciding with an uncorrectable transfer: clear wins.
    applyStimulus(1'b1, 32'h0, 6'b111111, 14'h0555);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    checkOutput("clrx_uncorr_cnt", 64'(UNCORR_CNT), 64'd0);
    checkOutput("clrx_log_valid", 64'(ERR_LOG_VALID), 64'd0);
    checkOutput("clrx_log_addr", 64'(ERR_LOG_ADDR), 64'd0);

    // Backpressure: 4 words, consumer stalls for 3 cycles once output is valid.
    k = 0;
    t = 0;
    while ((k < 4 || expQ.size() > 0) && t < 40) begin
      d = 32'h1234_5678 * (k + 1);
      p = encode(d) ^ 6'(k);
      if (k < 4) applyStimulus(1'b1, d, p, AW'(14'h0100 + k));
      else applyStimulus(1'b0, '0, '0, '0);
      OUT_READY = !(t >= 3 && t < 6);
      #1;
      if (t >= 3 && t < 6) checkOutput($sformatf("bp_in_ready_t%0d", t), 64'(IN_READY), 64'd0);
      tick();
      if (lastAccepted) k++;
      t++;
    end
    checkOutput("bp_all_accepted", 64'(k), 64'd4);
    checkOutput("bp_all_delivered", 64'(expQ.size()), 64'd0);

    // Saturation: 20 correctable words on a 4-bit counter.
    k = 0;
    t = 0;
    OUT_READY = 1'b1;
    while (k < 20 && t < 60) begin
      applyStimulus(1'b1, 32'h0, 6'b000011, AW'(k));
      tick();
      if (lastAccepted) k++;
      t++;
    end
    drain("sat_drain");
    tick();
    checkOutput("sat_corr_cnt", 64'(CORR_CNT), 64'd15);

    // Reset with two words in flight.
    applyStimulus(1'b1, 32'h0, 6'b000101, 14'h0300);
    tick();
    applyStimulus(1'b1, 32'h0, 6'b111110, 14'h0301);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    MEM_RST = 1'b1;
    tick();
    MEM_RST = 1'b0;
    checkOutput("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("midrst_corr_cnt", 64'(CORR_CNT), 64'd0);
    checkOutput("midrst_uncorr_cnt", 64'(UNCORR_CNT), 64'd0);
    checkOutput("midrst_in_ready", 64'(IN_READY), 64'd1);
    repeat (3) tick();

    // Randomized traffic with injected errors and random backpressure/clears.
    for (int i = 0; i < 600; i++) begin
      d = $urandom();
      p = encode(d);
      mode = int'($urandom_range(0, 3));
      case (mode)
        1: d = d ^ (32'd1 << $urandom_range(0, 31));
        2: p = p ^ (6'd1 << $urandom_range(0, 5));
        3: p = 6'($urandom_range(0, 63));
        default: ;
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), d, p, AW'($urandom()));
      OUT_READY = ($urandom_range(0, 4) != 0);
      CNT_CLR   = ($urandom_range(0, 49) == 0);
      tick();
    end
    CNT_CLR = 1'b0;
    drain("rand_drain");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
